// File: rtl/ball_miss_serve.sv
// ball_miss_serve: detects a ball miss in horizontal blanking, raises sc, pulses miss_l/miss_r
// and times the frame-counted serve delay. Optional macro SERVE_SIDE_EN registers serve_left.
module ball_miss_serve #(
  parameter int SERVE_FRAMES = 60,
  parameter int CNT_W        = 7
) (
  input  logic clk7_159,
  input  logic _reset,
  input  logic _hvid,
  input  logic _hblank,
  input  logic vreset,
  input  logic l,
  input  logic r,
  input  logic attract,
  input  logic game_over,
  output logic sc,
  output logic serve,
  output logic miss_l,
  output logic miss_r,
  output logic serve_left
);

  localparam logic [1:0] ST_PLAY   = 2'd0;
  localparam logic [1:0] ST_MISSED = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(SERVE_FRAMES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vreset_dly_q, vreset_dly_d;
  logic             rebound_q, rebound_d;
  logic             sc_q, sc_d;
  logic             serve_q, serve_d;
  logic             miss_l_q, miss_l_d;
  logic             miss_r_q, miss_r_d;
  logic             fe, hit, side_left, side_right;

  always_comb begin
    fe           = vreset & ~vreset_dly_q;
    hit          = ~_hvid & ~_hblank;
    side_left    = l & ~r;
    side_right   = r & ~l;
    vreset_dly_d = vreset;
    state_d      = state_q;
    cnt_d        = cnt_q;
    rebound_d    = rebound_q;
    miss_l_d     = 1'b0;
    miss_r_d     = 1'b0;
    case (state_q)
      ST_PLAY: begin
        // A hit on the same clock as a frame edge still enters MISSED; that edge is not reused.
        if (hit) begin
          state_d   = ST_MISSED;
          rebound_d = attract;
          miss_l_d  = ~attract & side_left;
          miss_r_d  = ~attract & side_right;
        end
      end
      ST_MISSED: begin
        if (fe) begin
          if (rebound_q) begin
            state_d = ST_PLAY;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (fe) begin
          if (attract) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else if (game_over) begin
            cnt_d = '0;
          end else if (cnt_q == LAST_FRAME) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
    // sc and serve are pure functions of the state being entered.
    sc_d    = (state_d == ST_MISSED);
    serve_d = (state_d != ST_WAIT);
  end

  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      vreset_dly_q <= 1'b0;
      rebound_q    <= 1'b0;
      sc_q         <= 1'b0;
      serve_q      <= 1'b0;
      miss_l_q     <= 1'b0;
      miss_r_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vreset_dly_q <= vreset_dly_d;
      rebound_q    <= rebound_d;
      sc_q         <= sc_d;
      serve_q      <= serve_d;
      miss_l_q     <= miss_l_d;
      miss_r_q     <= miss_r_d;
    end
  end

  assign sc     = sc_q;
  assign serve  = serve_q;
  assign miss_l = miss_l_q;
  assign miss_r = miss_r_q;

`ifdef SERVE_SIDE_EN
  logic serve_left_q, serve_left_d;

  // Next serve heads toward whoever missed; no-side and rebound hits leave it alone.
  always_comb begin
    serve_left_d = serve_left_q;
    if ((state_q == ST_PLAY) && hit && !attract) begin
      if (side_left) begin
        serve_left_d = 1'b1;
      end else if (side_right) begin
        serve_left_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      serve_left_q <= 1'b0;
    end else begin
      serve_left_q <= serve_left_d;
    end
  end

  assign serve_left = serve_left_q;
`else
  assign serve_left = 1'b0;
`endif

endmodule

// File: doc/ball_miss_serve.md
Name: ball_miss_serve

Overview:
- Detects the ball entering the horizontal blanking region, which is a miss at the left or right edge of the playfield.
- Drives the score-condition (sc) and serve controls consumed directly by ball_horizontal.
- Emits per-player miss pulses to the score counters.
- Times the post-miss serve delay in video frames; in attract mode the ball is rebounded instead of scored.

Parameters:
SERVE_FRAMES, 60, number of vreset rising edges counted in WAIT before serve reasserts (valid range 1..127)
CNT_W, 7, frame counter width; must satisfy 2^CNT_W > SERVE_FRAMES

Ports:
clk7_159  input  1  7.159 MHz system clock; all logic on rising edge
_reset  input  1  synchronous, active-low reset
_hvid  input  1  ball horizontal video from ball_horizontal, active low
_hblank  input  1  horizontal blanking, active low
vreset  input  1  vertical reset level, high during frame reset
l  input  1  ball moving left (from ball_horizontal)
r  input  1  ball moving right (from ball_horizontal)
attract  input  1  attract mode, active high
game_over  input  1  high when a player has reached winning score
sc  output  1  score condition to ball_horizontal, active high
serve  output  1  ball enabled / in play, active high
miss_l  output  1  one-clock pulse: left player missed (right player scores)
miss_r  output  1  one-clock pulse: right player missed (left player scores)
serve_left  output  1  side the next serve travels toward (see Optional Feature)

Behaviour:
- Interface: single clock clk7_159; _reset is synchronous, active-low.
- Reset (_reset=0 at a clock edge), taking effect that edge:
  - state=WAIT, frame counter=0, vreset_d=0.
  - sc=0, serve=0, miss_l=0, miss_r=0, serve_left=0.
  - Reset mid-operation aborts any pending miss or count.
- Frame edge: fe = vreset & ~vreset_d; vreset_d is registered every clock.
- Hit condition: hit = ~_hvid & ~_hblank, sampled each clock; evaluated only in PLAY.
- States: PLAY, MISSED, WAIT (2-bit encoding).
- PLAY:
  - serve=1.
  - On hit: next state MISSED; sc=1 from the next clock.
  - Side is latched at that clock:
    - l=1, r=0 -> side_left.
    - r=1, l=0 -> side_right.
    - l=r (both or neither) -> no side; sc is still raised, and no miss pulse is generated.
  - If attract=0 and a side is latched: one-clock pulse on miss_l (side_left) or miss_r (side_right), asserted the clock after hit.
  - If attract=1: no miss pulse; the rebound flag is latched.
- MISSED:
  - sc held at 1 until the first fe; further hits are ignored.
  - On fe: sc=0 next clock.
  - If the rebound flag is set: next state PLAY, serve stays 1.
  - Otherwise: next state WAIT, serve=0, counter cleared.
- WAIT:
  - serve=0.
  - Each fe increments the counter, except when game_over=1, which holds the counter at 0.
  - When fe occurs with counter==SERVE_FRAMES-1 and game_over=0: next state PLAY, serve=1 next clock, counter cleared.
  - attract=1 in WAIT exits to PLAY on the next fe, regardless of count or game_over.
- Simultaneous events:
  - fe and hit on the same PLAY clock: hit wins (enter MISSED); that fe is not consumed by MISSED.
  - _reset overrides all.
- Output timing: all outputs are registered; one clock of latency from input sampling.
- Miss pulses: never asserted for more than one clock per miss; never two pulses per MISSED visit.

Optional Feature:
Macro SERVE_SIDE_EN.
- Defined:
  - serve_left is registered and updated on entry to MISSED (non-rebound): 1 when side_left, 0 when side_right, unchanged when no side.
  - serve_left holds its value through WAIT and PLAY; ball serves toward the player who missed.
- Undefined:
  - serve_left is tied to 0; no extra flops.
  - All other behaviour is identical.

Test Plan:
- Reset then 60 vreset pulses, game_over=0 -> serve=0 until the clock after the 60th rising edge, then serve=1; sc, miss_l and miss_r all stay 0.
- PLAY, l=1 r=0, drive _hvid=0 and _hblank=0 for 3 clocks -> miss_l high exactly 1 clock; sc=1 until the clock after the next vreset edge; serve=0 from then; serve_left=1 with SERVE_SIDE_EN, 0 without.
- PLAY, attract=1, r=1, hit -> sc pulse lasting to the next frame edge; miss_r never asserts; serve stays 1; state returns to PLAY.
- WAIT with game_over=1 for 200 frames -> serve stays 0 and counter stays 0; release game_over -> serve=1 after exactly 60 further frame edges.
- Hit and vreset rising edge on the same clock in PLAY -> enters MISSED; sc stays 1 through that frame and drops after the following vreset edge.
- Assert _reset=0 for 1 clock during MISSED (sc=1) -> next clock sc=0, serve=0, WAIT with counter 0; l=r=1 hit afterward gives sc with no miss pulse.
